// File: rtl/debounce_array.sv
// debounce_array
//   Multi-channel push-button debouncer. Each channel is optionally
//   synchronised, then filtered so its debounced level only changes after
//   LIMIT consecutive samples at the new value. Each channel also provides
//   press/release strobes, a toggle state and a long-press strobe.
//
//   Ports
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     btn         raw button inputs, active high
//     mode        per channel: 0 = out follows level, 1 = out follows toggle
//     clr         synchronous clear of every toggle state
//     out         mode ? toggle state : debounced level
//     level       debounced level
//     rise, fall  one-cycle strobes on level 0->1 / 1->0
//     long_press  one-cycle strobe HOLD_LIMIT cycles after rise

module debounce_lane #(
   parameter int LIMIT       = 4,
   parameter int HOLD_LIMIT  = 1000,
   parameter int SYNC_STAGES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic mode,
   input  logic clr,
   output logic out,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);
   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT - 1);
   localparam logic [23:0]   HOLD_MAX = 24'(HOLD_LIMIT);

   logic          s;
   logic [CW-1:0] cnt;
   logic [23:0]   hcnt;
   logic          tgl;
   logic          accept;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = btn;
      end else if (SYNC_STAGES == 1) begin : g_sync1
         logic sq;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sq <= 1'b0;
            else        sq <= btn;
         assign s = sq;
      end else begin : g_syncn
         logic [SYNC_STAGES-1:0] sq;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sq <= '0;
            else        sq <= {sq[SYNC_STAGES-2:0], btn};
         assign s = sq[SYNC_STAGES-1];
      end
   endgenerate

   // LIMIT-th consecutive differing sample: level flips on this edge
   assign accept = (s != level) && (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         level      <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
         tgl        <= 1'b0;
         hcnt       <= '0;
         long_press <= 1'b0;
      end else begin
         // strobes are registered alongside level so they appear with it
         rise <= accept &  s;
         fall <= accept & ~s;

         if (s == level)          cnt <= '0;
         else if (cnt == CNT_MAX) begin
            level <= s;
            cnt   <= '0;
         end else                 cnt <= cnt + 1'b1;

         // toggle follows the visible rise strobe, so a clr in that same
         // cycle takes priority and the toggle stays cleared
         if (clr)       tgl <= 1'b0;
         else if (rise) tgl <= ~tgl;

         if (!level)                hcnt <= '0;
         else if (hcnt != HOLD_MAX) hcnt <= hcnt + 24'd1;

         // fires only on the step into HOLD_MAX; saturation blocks repeats
         long_press <= level && (hcnt == HOLD_MAX - 24'd1);
      end
   end

   assign out = mode ? tgl : level;
endmodule

module debounce_array #(
   parameter int CHANNELS    = 4,
   parameter int LIMIT       = 4,
   parameter int HOLD_LIMIT  = 1000,
   parameter int SYNC_STAGES = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] btn,
   input  logic [CHANNELS-1:0] mode,
   input  logic                clr,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press
);
   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
         debounce_lane #(
            .LIMIT       (LIMIT),
            .HOLD_LIMIT  (HOLD_LIMIT),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn        (btn[i]),
            .mode       (mode[i]),
            .clr        (clr),
            .out        (out[i]),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
         );
      end
   endgenerate
endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array
//   Directed bench: dut_a (LIMIT 4, HOLD_LIMIT 20, no synchroniser) covers
//   filtering, glitches, toggle/clr and long press; dut_b (SYNC_STAGES 2)
//   covers synchroniser latency and async reset mid-count.

module tb_debounce_array;
   logic       clk = 1'b0;
   logic       a_rst_n, b_rst_n;
   logic [3:0] a_btn, a_mode, b_btn, b_mode;
   logic       a_clr, b_clr;
   logic [3:0] a_out, a_level, a_rise, a_fall, a_lp;
   logic [3:0] b_out, b_level, b_rise, b_fall, b_lp;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   debounce_array #(.CHANNELS(4), .LIMIT(4), .HOLD_LIMIT(20), .SYNC_STAGES(0)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .btn(a_btn), .mode(a_mode), .clr(a_clr),
      .out(a_out), .level(a_level), .rise(a_rise), .fall(a_fall), .long_press(a_lp));

   debounce_array #(.CHANNELS(4), .LIMIT(4), .HOLD_LIMIT(20), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .btn(b_btn), .mode(b_mode), .clr(b_clr),
      .out(b_out), .level(b_level), .rise(b_rise), .fall(b_fall), .long_press(b_lp));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, land 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one clean press/release on channel 2; reports level seen while held
   task automatic press2(output logic lv);
      a_btn[2] = 1'b1;
      step(4);
      lv = a_level[2];
      step(1);
      a_btn[2] = 1'b0;
      step(6);
   endtask

   initial begin
      logic [3:0] acc;
      logic       lv;
      int         n_lp, at_lp;

      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_btn = '0; a_mode = '0; a_clr = 1'b0;
      b_btn = '0; b_mode = '0; b_clr = 1'b0;
      step(2);
      check("reset_a", {12'd0, a_out, a_level, a_rise, a_fall, a_lp}, 32'd0);
      check("reset_b", {12'd0, b_out, b_level, b_rise, b_fall, b_lp}, 32'd0);
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      step(2);

      // clean press on channel 0: level/rise after the 4th edge
      a_btn[0] = 1'b1;
      acc = '0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         acc |= {2'b0, a_level[0], a_fall[0]};
      end
      check("press0_early", {28'd0, acc}, 32'd0);
      step(1);
      check("press0_level", {31'd0, a_level[0]}, 32'd1);
      check("press0_rise",  {31'd0, a_rise[0]},  32'd1);
      check("press0_out",   {31'd0, a_out[0]},   32'd1);
      acc = '0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         acc |= {2'b0, a_rise[0], a_fall[0]};
      end
      check("press0_single", {28'd0, acc}, 32'd0);
      check("press0_hold",   {31'd0, a_level[0]}, 32'd1);
      a_btn[0] = 1'b0;
      step(6);

      // glitches of 3 cycles on channel 1 never pass
      acc = '0;
      for (int r = 0; r < 10; r++) begin
         a_btn[1] = 1'b1;
         for (int i = 0; i < 3; i++) begin
            step(1);
            acc |= {1'b0, a_level[1], a_rise[1], a_out[1]};
         end
         a_btn[1] = 1'b0;
         for (int i = 0; i < 3; i++) begin
            step(1);
            acc |= {1'b0, a_level[1], a_rise[1], a_out[1]};
         end
      end
      check("glitch1", {28'd0, acc}, 32'd0);

      // toggle mode on channel 2
      a_mode[2] = 1'b1;
      press2(lv);
      check("tgl_lv1",  {31'd0, lv}, 32'd1);
      check("tgl_out1", {31'd0, a_out[2]}, 32'd1);
      check("tgl_rel1", {31'd0, a_level[2]}, 32'd0);
      press2(lv);
      check("tgl_lv2",  {31'd0, lv}, 32'd1);
      check("tgl_out2", {31'd0, a_out[2]}, 32'd0);
      press2(lv);
      check("tgl_lv3",  {31'd0, lv}, 32'd1);
      check("tgl_out3", {31'd0, a_out[2]}, 32'd1);
      a_clr = 1'b1;
      step(1);
      a_clr = 1'b0;
      check("tgl_clr", {31'd0, a_out[2]}, 32'd0);
      // clr in the same cycle as the rise strobe
      a_btn[2] = 1'b1;
      step(4);
      check("tgl_rise4", {31'd0, a_rise[2]}, 32'd1);
      a_clr = 1'b1;
      step(1);
      a_clr = 1'b0;
      check("tgl_clr_rise", {31'd0, a_out[2]}, 32'd0);
      step(2);
      check("tgl_clr_rise2", {31'd0, a_out[2]}, 32'd0);
      // mode switch is combinational and leaves toggle alone
      a_mode[2] = 1'b0;
      #1;
      check("mode_level", {31'd0, a_out[2]}, 32'd1);
      a_mode[2] = 1'b1;
      #1;
      check("mode_tgl", {31'd0, a_out[2]}, 32'd0);
      a_btn[2] = 1'b0;
      step(6);

      // long press on channel 3
      a_btn[3] = 1'b1;
      step(4);
      check("lp_rise", {31'd0, a_rise[3]}, 32'd1);
      n_lp = 0; at_lp = 0;
      for (int i = 1; i <= 36; i++) begin
         step(1);
         if (a_lp[3]) begin
            n_lp++;
            at_lp = i;
         end
      end
      check("lp_count", n_lp, 1);
      check("lp_delay", at_lp, 20);
      a_btn[3] = 1'b0;
      step(6);
      n_lp = 0;
      a_btn[3] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (a_lp[3]) n_lp++;
      end
      a_btn[3] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (a_lp[3]) n_lp++;
      end
      check("lp_short", n_lp, 0);

      // synchroniser: all four rise together 6 edges after change
      b_btn = 4'hF;
      step(5);
      check("sync_early", {28'd0, b_rise}, 32'd0);
      step(1);
      check("sync_rise",  {28'd0, b_rise},  32'hF);
      check("sync_level", {28'd0, b_level}, 32'hF);
      // async reset while a release is being counted
      b_btn = 4'h0;
      step(3);
      b_rst_n = 1'b0;
      #1;
      check("arst_now", {12'd0, b_out, b_level, b_rise, b_fall, b_lp}, 32'd0);
      step(2);
      b_rst_n = 1'b1;
      acc = '0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         acc |= b_rise | b_fall | b_lp | b_level;
      end
      check("arst_quiet", {28'd0, acc}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
